midi_fifo_arbiter: RTL and testbench

Shares the single MIDI byte FIFO among `N_PORTS` MIDI receiver modules. Each receiver presents bytes with a request/last-byte flag. The arbiter grants the FIFO write port round-robin and keeps a grant locked to one receiver until that receiver's message is complete, so messages never interleave. It sits between the receiver bank and the `fifo` write side (`wr`, `data_i`, `oe_n`, `full_n`). It runs on the same clock as the FIFO.

---
 rtl/midi_router_pkg.sv | 12 +
 rtl/midi_fifo_arbiter_if.sv | 30 +++
 rtl/midi_rr_pick.sv | 33 +++
 rtl/midi_fifo_arbiter.sv | 130 +++++++++++++
 tb/tb_midi_fifo_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_router_pkg.sv
// rtl/midi_router_pkg.sv - shared types and default sizing for the MIDI FIFO arbiter
package midi_router_pkg;
    localparam int N_PORTS_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1024;
    localparam int IDX_W_DEF   = $clog2(N_PORTS_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;
endpackage

// File: rtl/midi_fifo_arbiter_if.sv
// rtl/midi_fifo_arbiter_if.sv - receiver-bank and FIFO write-side signals of the MIDI arbiter
interface midi_fifo_arbiter_if
    import midi_router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = IDX_W_DEF
);
    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        last;
    logic [N_PORTS*DATA_W-1:0] data_in;
    logic [N_PORTS-1:0]        ack;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_data;
    logic                      fifo_oe_n;
    logic                      fifo_full_n;
    logic [IDX_W-1:0]          owner;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output req, last, data_in, fifo_full_n,
        input  ack, fifo_wr, fifo_data, fifo_oe_n, owner, busy, timeout_err
    );

    modport slave (
        input  req, last, data_in, fifo_full_n,
        output ack, fifo_wr, fifo_data, fifo_oe_n, owner, busy, timeout_err
    );
endinterface

// File: rtl/midi_rr_pick.sv
// rtl/midi_rr_pick.sv - combinational round-robin picker: first eligible requester at or after rr_ptr
module midi_rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [N_PORTS-1:0] cand;

    assign cand = req & eligible;

    // Scan from the farthest offset down so the nearest candidate to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int off = N_PORTS - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (cand[IDX_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/midi_fifo_arbiter.sv
// rtl/midi_fifo_arbiter.sv - round-robin arbiter that locks the FIFO write port to one receiver per MIDI message
module midi_fifo_arbiter
    import midi_router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    midi_fifo_arbiter_if.slave bus
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t         state, state_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_nx;
    logic [IDX_W-1:0]   owner, owner_nx;
    logic [IDX_W-1:0]   grant_idx, sel_idx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [N_PORTS-1:0] ack, ack_nx;
    logic               fifo_wr, wr_nx;
    logic               oe_n;
    logic               terr, terr_nx;
    logic               grant_valid;
    logic [DATA_W-1:0]  fifo_data, data_nx, sel_data;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    // A port acked this cycle still holds its old byte, so it is masked out of the new grant.
    midi_rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (bus.req),
        .eligible    (~ack),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_idx  = (state == LOCKED) ? owner : grant_idx;
    assign sel_data = bus.data_in[sel_idx*DATA_W +: DATA_W];

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        ack_nx   = '0;
        wr_nx    = 1'b0;
        data_nx  = fifo_data;
        terr_nx  = 1'b0;
        // A full FIFO freezes everything, including the idle counter.
        if (bus.fifo_full_n) begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        wr_nx             = 1'b1;
                        data_nx           = sel_data;
                        ack_nx[grant_idx] = 1'b1;
                        owner_nx          = grant_idx;
                        cnt_nx            = '0;
                        if (bus.last[grant_idx]) begin
                            rr_nx = next_idx(grant_idx);
                        end else begin
                            state_nx = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (bus.req[owner] && !ack[owner]) begin
                        wr_nx         = 1'b1;
                        data_nx       = sel_data;
                        ack_nx[owner] = 1'b1;
                        cnt_nx        = '0;
                        if (bus.last[owner]) begin
                            state_nx = IDLE;
                            rr_nx    = next_idx(owner);
                        end
                    end else if (!bus.req[owner]) begin
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            terr_nx  = 1'b1;
                            state_nx = IDLE;
                            rr_nx    = next_idx(owner);
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            ack       <= '0;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
            oe_n      <= 1'b1;
            terr      <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            owner     <= owner_nx;
            cnt       <= cnt_nx;
            ack       <= ack_nx;
            fifo_wr   <= wr_nx;
            fifo_data <= data_nx;
            oe_n      <= 1'b0;
            terr      <= terr_nx;
        end
    end

    assign bus.ack         = ack;
    assign bus.fifo_wr     = fifo_wr;
    assign bus.fifo_data   = fifo_data;
    assign bus.fifo_oe_n   = oe_n;
    assign bus.owner       = owner;
    assign bus.busy        = (state == LOCKED);
    assign bus.timeout_err = terr;
endmodule

// File: tb/tb_midi_fifo_arbiter.sv
// tb/tb_midi_fifo_arbiter.sv - self-checking bench for midi_fifo_arbiter with a message-level reference model
module tb_midi_fifo_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       busy;
        int         cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    midi_fifo_arbiter_if #(.N_PORTS(NP), .DATA_W(DW), .IDX_W(2)) bus ();

    midi_fifo_arbiter #(.N_PORTS(NP), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    logic [8:0] pq [NP][$];
    bit         pop_due [NP];
    wr_t        wlog [$];
    int         lock_port = -1;
    int         n_total = 0;
    int         n_pass = 0;
    int         n_terr = 0;
    int         terr_cyc = 0;
    int         cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive();
        logic [NP-1:0]    r, l;
        logic [NP*DW-1:0] d;
        logic [8:0]       hd;
        r = '0; l = '0; d = '0;
        for (int i = 0; i < NP; i++) begin
            if (pq[i].size() > 0) begin
                hd = pq[i][0];
                r[i] = 1'b1;
                l[i] = hd[8];
                d[i*DW +: DW] = hd[7:0];
            end
        end
        bus.req = r;
        bus.last = l;
        bus.data_in = d;
    endtask

    task automatic do_pops();
        logic [8:0] tmp;
        for (int i = 0; i < NP; i++) begin
            if (pop_due[i]) begin
                if (pq[i].size() > 0) tmp = pq[i].pop_front();
                pop_due[i] = 1'b0;
            end
        end
    endtask

    // One clock: requesters update on the edge after seeing ack; the model checks every write.
    task automatic step();
        logic       full_edge;
        logic [3:0] a;
        logic [8:0] hd;
        int         p;
        wr_t        w;
        full_edge = bus.fifo_full_n;
        @(posedge clk);
        #1;
        cyc++;
        do_pops();
        a = bus.ack;
        chk("wr_vs_ack", bus.fifo_wr, (a != 4'b0));
        chk("ack_onehot", ($countones(a) <= 1), 1);
        if (!full_edge) chk("full_no_wr", bus.fifo_wr, 0);
        if (bus.fifo_wr && a != 4'b0) begin
            p = 0;
            for (int i = NP - 1; i >= 0; i--) if (a[i]) p = i;
            chk("ack_has_byte", (pq[p].size() > 0), 1);
            if (pq[p].size() > 0) begin
                hd = pq[p][0];
                chk("fifo_data", bus.fifo_data, hd[7:0]);
                if (lock_port >= 0) chk("no_interleave", p, lock_port);
                lock_port = hd[8] ? -1 : p;
                w.port = p; w.data = bus.fifo_data; w.busy = bus.busy; w.cyc = cyc;
                wlog.push_back(w);
            end
            pop_due[p] = 1'b1;
        end
        if (bus.timeout_err) begin
            n_terr++;
            terr_cyc = cyc;
            lock_port = -1;
        end
        chk("busy", bus.busy, (lock_port >= 0));
        if (lock_port >= 0) chk("owner", bus.owner, lock_port);
        drive();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, bus.ack, 0);
        chk({tag, "_wr"}, bus.fifo_wr, 0);
        chk({tag, "_data"}, bus.fifo_data, 0);
        chk({tag, "_oe_n"}, bus.fifo_oe_n, 1);
        chk({tag, "_owner"}, bus.owner, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
    endtask

    initial begin
        int t0, nt0, len, pushed, k;
        logic [8:0] b;

        // Reset
        bus.fifo_full_n = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        step();
        chk("oe_after_reset", bus.fifo_oe_n, 0);
        chk("wr_after_reset", bus.fifo_wr, 0);

        // Fairness: four single-byte messages at once
        wlog.delete();
        for (int i = 0; i < NP; i++) pq[i].push_back({1'b1, 8'(i + 1)});
        drive();
        for (k = 0; k < 20 && wlog.size() < 4; k++) step();
        chk("fair_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fair_data", wlog[i].data, i + 1);
                chk("fair_port", wlog[i].port, i);
            end
            chk("fair_back_to_back", wlog[3].cyc - wlog[0].cyc, 3);
        end
        repeat (3) step();
        chk("fair_no_extra", wlog.size(), 4);

        // Pointer back at 0: port 1 wins over port 3
        wlog.delete();
        pq[3].push_back({1'b1, 8'h33});
        pq[1].push_back({1'b1, 8'h11});
        drive();
        for (k = 0; k < 20 && wlog.size() < 2; k++) step();
        chk("rr_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("rr_first", wlog[0].port, 1);
            chk("rr_second", wlog[1].port, 3);
        end
        repeat (3) step();

        // Lock: port 2 message is not interleaved by port 0
        wlog.delete();
        pq[2].push_back({1'b0, 8'h90});
        pq[2].push_back({1'b0, 8'h3C});
        pq[2].push_back({1'b1, 8'h40});
        drive();
        step();
        pq[0].push_back({1'b1, 8'hF8});
        drive();
        for (k = 0; k < 30 && wlog.size() < 4; k++) step();
        chk("lock_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("lock_d0", wlog[0].data, 8'h90);
            chk("lock_d1", wlog[1].data, 8'h3C);
            chk("lock_d2", wlog[2].data, 8'h40);
            chk("lock_d3", wlog[3].data, 8'hF8);
            chk("lock_busy0", wlog[0].busy, 1);
            chk("lock_busy1", wlog[1].busy, 1);
            chk("lock_busy2", wlog[2].busy, 0);
        end
        repeat (3) step();

        // Full stall
        wlog.delete();
        nt0 = n_terr;
        bus.fifo_full_n = 1'b0;
        pq[1].push_back({1'b1, 8'h55});
        drive();
        repeat (20) step();
        chk("stall_no_wr", wlog.size(), 0);
        chk("stall_no_terr", n_terr - nt0, 0);
        bus.fifo_full_n = 1'b1;
        repeat (10) step();
        chk("stall_once", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("stall_data", wlog[0].data, 8'h55);
            chk("stall_port", wlog[0].port, 1);
        end

        // Timeout: port 3 abandons its message, port 0 waits
        wlog.delete();
        nt0 = n_terr;
        pq[3].push_back({1'b0, 8'h80});
        pq[0].push_back({1'b1, 8'h07});
        drive();
        step();
        t0 = cyc;
        chk("to_first_port", (wlog.size() == 1) ? wlog[0].port : -1, 3);
        for (k = 0; k < 40 && n_terr == nt0; k++) step();
        chk("to_seen", n_terr - nt0, 1);
        chk("to_delay", terr_cyc - t0, 17);
        chk("to_busy", bus.busy, 0);
        step();
        chk("to_pulse_one", bus.timeout_err, 0);
        chk("to_next_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("to_next_port", wlog[1].port, 0);
            chk("to_next_data", wlog[1].data, 8'h07);
        end
        repeat (3) step();

        // Reset in the middle of port 1's message
        wlog.delete();
        pq[1].push_back({1'b0, 8'h11});
        pq[1].push_back({1'b1, 8'h12});
        pq[2].push_back({1'b1, 8'h22});
        drive();
        step();
        chk("mid_first_port", (wlog.size() == 1) ? wlog[0].port : -1, 1);
        chk("mid_locked", bus.busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        do_pops();
        lock_port = -1;
        drive();
        @(posedge clk);
        #1;
        chk("mid_hold_wr", bus.fifo_wr, 0);
        reset_n = 1'b1;
        wlog.delete();
        for (k = 0; k < 20 && wlog.size() < 2; k++) step();
        chk("mid_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("mid_p1_port", wlog[0].port, 1);
            chk("mid_p1_data", wlog[0].data, 8'h12);
            chk("mid_p2_port", wlog[1].port, 2);
        end
        repeat (3) step();

        // Randomized traffic against the message-level model
        wlog.delete();
        nt0 = n_terr;
        pushed = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (pq[i].size() < 2 && $urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        b = {(j == len - 1), 8'($urandom)};
                        pq[i].push_back(b);
                        pushed++;
                    end
                end
            end
            bus.fifo_full_n = ($urandom_range(0, 4) != 0);
            drive();
            step();
        end
        bus.fifo_full_n = 1'b1;
        for (k = 0; k < 400 && (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) != 0; k++) step();
        repeat (2) step();
        chk("rand_drained", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);
        chk("rand_all_written", wlog.size(), pushed);
        chk("rand_no_terr", n_terr - nt0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
